// File: rtl/issue_pipe_slot.sv
// Issue-path pipeline slot between decode and operand fetch: N-lane groups,
// two-entry skid buffer, registered in_ready, sticky sideband and stall counter.
module issue_pipe_slot #(
    parameter int LANES    = 2,
    parameter int DATA_W   = 160,
    parameter int STICKY_W = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [STICKY_W-1:0]     in_sticky,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [STICKY_W-1:0]     out_sticky,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);
    localparam int PW = LANES * DATA_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e                occ_q, occ_d;
    logic [LANES-1:0]    main_mask_q, main_mask_d;
    logic [PW-1:0]       main_data_q, main_data_d;
    logic [LANES-1:0]    skid_mask_q, skid_mask_d;
    logic [PW-1:0]       skid_data_q, skid_data_d;
    logic                rdy_q, rdy_d;
    logic [STICKY_W-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic          in_any_s, in_fire_s, head_v_s, out_fire_s;
    logic [PW-1:0] in_clean_s;

    // Lanes that are not valid carry the all-zero NOP payload.
    function automatic logic [PW-1:0] zero_idle_lanes(input logic [LANES-1:0] v,
                                                      input logic [PW-1:0]    d);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) begin
                r[i*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
            end else begin
                r[i*DATA_W +: DATA_W] = '0;
            end
        end
        return r;
    endfunction

    // Handshake terms and next-state for both entries, occupancy and sideband.
    always_comb begin
        in_any_s    = |in_valid;
        in_fire_s   = in_any_s & rdy_q;
        head_v_s    = (occ_q != OCC_EMPTY);
        out_fire_s  = head_v_s & out_ready;
        in_clean_s  = zero_idle_lanes(in_valid, in_data);

        occ_d       = occ_q;
        main_mask_d = main_mask_q;
        main_data_d = main_data_q;
        skid_mask_d = skid_mask_q;
        skid_data_d = skid_data_q;
        sticky_d    = sticky_q;

        case (occ_q)
            OCC_EMPTY: begin
                if (in_fire_s) begin
                    main_mask_d = in_valid;
                    main_data_d = in_clean_s;
                    occ_d       = OCC_ONE;
                end else begin
                    occ_d       = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_mask_d = in_valid;
                    main_data_d = in_clean_s;
                end else if (in_fire_s) begin
                    skid_mask_d = in_valid;
                    skid_data_d = in_clean_s;
                    occ_d       = OCC_TWO;
                end else if (out_fire_s) begin
                    main_mask_d = '0;
                    main_data_d = '0;
                    occ_d       = OCC_EMPTY;
                end else begin
                    occ_d       = OCC_ONE;
                end
            end
            OCC_TWO: begin
                if (out_fire_s) begin
                    main_mask_d = skid_mask_q;
                    main_data_d = skid_data_q;
                    skid_mask_d = '0;
                    skid_data_d = '0;
                    occ_d       = OCC_ONE;
                end else begin
                    occ_d       = OCC_TWO;
                end
            end
            default: begin
                main_mask_d = '0;
                main_data_d = '0;
                skid_mask_d = '0;
                skid_data_d = '0;
                occ_d       = OCC_EMPTY;
            end
        endcase

        if (in_fire_s) begin
            sticky_d = in_sticky;
        end else begin
            sticky_d = sticky_q;
        end

        // Flush kills everything held plus whatever fired this cycle.
        if (flush) begin
            main_mask_d = '0;
            main_data_d = '0;
            skid_mask_d = '0;
            skid_data_d = '0;
            sticky_d    = '0;
            occ_d       = OCC_EMPTY;
        end else begin
            occ_d       = occ_d;
        end

        rdy_d = (occ_d != OCC_TWO);

        if (head_v_s && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // All slot state; reset drops both entries without waiting for a clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ_q       <= OCC_EMPTY;
            main_mask_q <= '0;
            main_data_q <= '0;
            skid_mask_q <= '0;
            skid_data_q <= '0;
            rdy_q       <= 1'b0;
            sticky_q    <= '0;
            stall_q     <= '0;
        end else begin
            occ_q       <= occ_d;
            main_mask_q <= main_mask_d;
            main_data_q <= main_data_d;
            skid_mask_q <= skid_mask_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
            sticky_q    <= sticky_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = main_mask_q;
    assign out_data   = main_data_q;
    assign out_sticky = sticky_q;
    assign occupancy  = occ_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_issue_pipe_slot.sv
// Self-checking bench for issue_pipe_slot: vector table plus queue scoreboard,
// with a second instance using a 3-bit stall counter to exercise saturation.
module tb_issue_pipe_slot;
    localparam int LANES  = 2;
    localparam int DATA_W = 160;
    localparam int PW     = LANES * DATA_W;

    typedef logic [PW-1:0] w_t;

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] seed;
        logic       stk;
        logic       ordy;
        logic       fl;
        logic [1:0] occ;
    } vec_t;

    typedef struct packed {
        logic [1:0]    mask;
        logic [PW-1:0] data;
    } grp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic [1:0]    in_valid;
    logic [PW-1:0] in_data;
    logic [0:0]    in_sticky;
    logic          out_ready;

    logic          in_ready, in_ready3;
    logic [1:0]    out_valid, out_valid3;
    logic [PW-1:0] out_data, out_data3;
    logic [0:0]    out_sticky, out_sticky3;
    logic [1:0]    occupancy, occupancy3;
    logic [15:0]   stall_cnt;
    logic [2:0]    stall_cnt3;

    issue_pipe_slot #(.LANES(LANES), .DATA_W(DATA_W), .STICKY_W(1), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_sticky(in_sticky), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_sticky(out_sticky), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    issue_pipe_slot #(.LANES(LANES), .DATA_W(DATA_W), .STICKY_W(1), .CNT_W(3)) dut3 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_sticky(in_sticky), .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ready(out_ready), .out_sticky(out_sticky3), .occupancy(occupancy3), .stall_cnt(stall_cnt3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    grp_t        sbq[$];
    logic        m_rdy;
    logic        m_sticky;
    logic [15:0] m_stall16;
    logic [2:0]  m_stall3;

    vec_t tbl[33];

    task automatic chk(input string nm, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic w_t mk_data(input logic [7:0] seed);
        w_t r;
        if (seed == 8'hFF) begin
            r = '1;
        end else begin
            r = '0;
            for (int i = 0; i < LANES; i++) begin
                r[i*DATA_W +: DATA_W] = {{19{seed}}, seed ^ 8'(i + 1)};
            end
        end
        return r;
    endfunction

    function automatic w_t clean(input logic [1:0] v, input w_t d);
        w_t r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) r[i*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    task automatic check_all();
        w_t exp_mask;
        w_t exp_data;
        exp_mask = '0;
        exp_data = '0;
        if (sbq.size() != 0) begin
            exp_mask = w_t'(sbq[0].mask);
            exp_data = sbq[0].data;
        end
        chk("occupancy",  w_t'(occupancy),  w_t'(sbq.size()));
        chk("in_ready",   w_t'(in_ready),   w_t'(m_rdy));
        chk("out_valid",  w_t'(out_valid),  exp_mask);
        chk("out_data",   out_data,         exp_data);
        chk("out_sticky", w_t'(out_sticky), w_t'(m_sticky));
        chk("stall_cnt",  w_t'(stall_cnt),  w_t'(m_stall16));
        chk("occupancy3", w_t'(occupancy3), w_t'(sbq.size()));
        chk("stall_cnt3", w_t'(stall_cnt3), w_t'(m_stall3));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   w_t'(in_ready),   '0);
        chk({tag, "_out_valid"},  w_t'(out_valid),  '0);
        chk({tag, "_out_data"},   out_data,         '0);
        chk({tag, "_out_sticky"}, w_t'(out_sticky), '0);
        chk({tag, "_occupancy"},  w_t'(occupancy),  '0);
        chk({tag, "_stall_cnt"},  w_t'(stall_cnt),  '0);
        chk({tag, "_stall_cnt3"}, w_t'(stall_cnt3), '0);
        chk({tag, "_out_data3"},  out_data3,        '0);
    endtask

    task automatic model_reset();
        sbq.delete();
        m_rdy     = 1'b0;
        m_sticky  = 1'b0;
        m_stall16 = 16'd0;
        m_stall3  = 3'd0;
    endtask

    task automatic idle_inputs();
        in_valid  = 2'b00;
        in_data   = '0;
        in_sticky = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic step(input vec_t t, input int idx);
        logic in_fire, out_fire;
        grp_t g;
        in_valid  = t.v;
        in_data   = mk_data(t.seed);
        in_sticky = t.stk;
        out_ready = t.ordy;
        flush     = t.fl;
        in_fire   = (|t.v) && m_rdy;
        out_fire  = (sbq.size() != 0) && t.ordy;
        @(posedge clk);
        #1;
        if (t.fl) begin
            sbq.delete();
            m_sticky = 1'b0;
        end else begin
            if ((sbq.size() != 0) && !t.ordy) begin
                if (m_stall16 != 16'hFFFF) m_stall16 = m_stall16 + 16'd1;
                if (m_stall3 != 3'd7)      m_stall3  = m_stall3 + 3'd1;
            end
            if (out_fire) void'(sbq.pop_front());
            if (in_fire) begin
                g.mask = t.v;
                g.data = clean(t.v, mk_data(t.seed));
                sbq.push_back(g);
                m_sticky = t.stk;
            end
        end
        m_rdy = (sbq.size() != 2);
        chk($sformatf("vec%0d_occ", idx), w_t'(occupancy), w_t'(t.occ));
        check_all();
    endtask

    initial begin
        //           v      seed   stk   ordy  fl    occ
        tbl[0]  = '{2'b11, 8'hA1, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[1]  = '{2'b11, 8'hA2, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{2'b11, 8'hA3, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[3]  = '{2'b11, 8'hA4, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[4]  = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{2'b11, 8'hB1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[6]  = '{2'b11, 8'hB2, 1'b0, 1'b0, 1'b0, 2'd2};
        tbl[7]  = '{2'b11, 8'hB3, 1'b0, 1'b0, 1'b0, 2'd2};
        tbl[8]  = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[9]  = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[10] = '{2'b01, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[11] = '{2'b00, 8'h3C, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[12] = '{2'b00, 8'h3C, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{2'b00, 8'h3C, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[14] = '{2'b10, 8'hC1, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[15] = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{2'b11, 8'hD1, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[17] = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[18] = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[19] = '{2'b01, 8'hD2, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[20] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[21] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[22] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[23] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[24] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[25] = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[26] = '{2'b11, 8'hE1, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[27] = '{2'b11, 8'hE2, 1'b1, 1'b0, 1'b0, 2'd2};
        tbl[28] = '{2'b11, 8'hE3, 1'b1, 1'b1, 1'b1, 2'd0};
        tbl[29] = '{2'b11, 8'hF1, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[30] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[31] = '{2'b11, 8'hF2, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[32] = '{2'b11, 8'hF3, 1'b0, 1'b0, 1'b0, 2'd2};

        idle_inputs();
        model_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rdy_before_first_edge", w_t'(in_ready), '0);

        step('{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0}, 100);

        for (int i = 0; i < 33; i++) begin
            step(tbl[i], i);
        end

        chk("stall_total16", w_t'(stall_cnt),  w_t'(16'd10));
        chk("stall_sat3",    w_t'(stall_cnt3), w_t'(3'd7));

        // Full slot: reset asserted between edges must clear outputs at once.
        #2;
        resetn = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        check_reset_vals("async_held");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rdy_after_release", w_t'(in_ready), '0);

        step('{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0}, 200);
        step('{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0}, 201);
        step('{2'b11, 8'h71, 1'b1, 1'b1, 1'b0, 2'd1}, 202);
        step('{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0}, 203);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/issue_pipe_slot.md
Name: issue_pipe_slot

Overview:
- Parametrised N-lane pipeline register for the issue path, placed between decode and operand fetch. It generalises the fixed dual-issue ID/OF register.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream ready does not depend combinationally on the downstream ready.
- Supports per-lane valid masks, flush, a sticky sideband field (delay-slot hint) and a saturating stall-cycle counter.
- Bubbles and empty lanes present an all-zero payload, which is the team's NOP encoding.

Parameters:
- LANES, 2, number of instruction lanes; legal range 1..4.
- DATA_W, 160, payload bits per lane (pc, reg addrs, imm, aluop, wb info, exc type).
- STICKY_W, 1, width of the sideband that holds across bubbles.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries; highest priority after reset.
- in_valid  in  LANES  per-lane valid from decode.
- in_data  in  LANES*DATA_W  lane payloads; lane i occupies bits [i*DATA_W +: DATA_W].
- in_sticky  in  STICKY_W  sideband captured with each accepted group.
- in_ready  out  1  registered; the slot can accept a group next edge.
- out_valid  out  LANES  per-lane valid toward operand fetch.
- out_data  out  LANES*DATA_W  head payload; a lane is zero when its out_valid bit is 0.
- out_ready  in  1  operand fetch consumes the head group this edge.
- out_sticky  out  STICKY_W  last captured sideband.
- occupancy  out  2  number of groups held (0..2).
- stall_cnt  out  CNT_W  cycles in which the head was valid and out_ready was 0.

Behaviour:
- Group semantics
  - A group is the set of lanes presented in one cycle.
  - in_any = |in_valid.
  - in_fire = in_any & in_ready.
  - head_v = occupancy != 0.
  - out_fire = head_v & out_ready.
  - A cycle with in_any = 0 is not a transfer; in_data is ignored.
- Storage
  - Two entries, MAIN and SKID, each holding a lane valid mask plus LANES*DATA_W data.
  - Data of a lane whose captured valid bit is 0 is stored as zero.
- State machine on occupancy
  - EMPTY (0):
    - in_fire: MAIN <= in, go to ONE.
    - otherwise stay.
  - ONE (1):
    - in_fire & out_fire: MAIN <= in, stay in ONE.
    - in_fire only: SKID <= in, go to TWO.
    - out_fire only: clear MAIN, go to EMPTY.
  - TWO (2):
    - in_ready is 0.
    - out_fire: MAIN <= SKID, clear SKID, go to ONE.
    - otherwise hold both entries.
- in_ready is registered and equals (next occupancy != 2).
  - Consequence: an accept in ONE without a drain deasserts in_ready on the following cycle. SKID absorbs the group accepted that cycle.
- out_valid = MAIN mask when head_v, else 0. out_data = MAIN data, zero when EMPTY.
- Sticky sideband
  - out_sticky <= in_sticky on every in_fire.
  - It holds through bubbles and drains, i.e. it is never cleared by an EMPTY transition.
- Flush
  - When flush = 1 at an edge: MAIN, SKID, out_sticky and occupancy are cleared, and in_ready <= 1.
  - Any in_fire or out_fire in that cycle is discarded. Upstream treats its group as killed.
  - stall_cnt is not cleared by flush.
- stall_cnt
  - Increments by 1 on each edge with head_v & !out_ready & !flush.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset (resetn = 0, asynchronous)
  - Outputs: out_valid = 0, out_data = 0, out_sticky = 0, occupancy = 0, stall_cnt = 0, in_ready = 0.
  - in_ready rises to 1 on the first clk edge after resetn deasserts.
  - Reset asserted mid-operation drops both entries immediately, without waiting for a clock edge.
- Latency
  - An accepted group is visible on out_* one cycle after its in_fire edge when the slot was EMPTY.
  - Throughput is one group per cycle while out_ready = 1.
- LANES = 1 degenerates to a single-lane skid register; all rules are unchanged.

Test Plan:
1. Reset and flow: release resetn. Check in_ready = 0 until the first edge, then 1. Drive in_valid = 2'b11 with data A, out_ready = 1, for 4 groups. Each group must appear on out_* one cycle after it is accepted, with occupancy staying at 1.
2. Skid fill: hold out_ready = 0 and send groups A and B on consecutive cycles.
   - Expect occupancy 1 then 2, in_ready = 0 after B, and out_data = A held.
   - Set out_ready = 1: A drains, then B, then occupancy returns to 0.
3. Lane mask: in_valid = 2'b01 with lane 1 data 0xFFFF... must give out_valid = 2'b01 and out_data lane 1 = 0. Also check that in_valid = 0 never changes occupancy.
4. Flush with a full slot: with occupancy = 2, assert flush together with in_valid = 2'b11 and out_ready = 1.
   - Next cycle: occupancy = 0, out_valid = 0, out_sticky = 0, in_ready = 1.
   - stall_cnt is unchanged.
5. Sticky and stall count: accept a group with in_sticky = 1, then drain it.
   - out_sticky stays 1 while EMPTY.
   - Next, hold out_ready = 0 for 5 cycles with one group held: stall_cnt += 5.
   - Run with CNT_W = 3 for 10 stalled cycles: stall_cnt = 7, no wrap.
6. Async reset mid-operation: pulse resetn low between clock edges while occupancy = 2. All outputs must go to their reset values immediately, and no stale group may appear after release.
